// File: rtl/clock_gate_ctrl.sv
`timescale 1ns/1ps
// Per-channel clock gating: each channel has an OFF/ON/IDLE FSM with an idle
// counter; the registered enable is re-timed by a low-transparent latch into an AND gate.
module clock_gate_ctrl #(
    parameter int N_CH        = 4,
    parameter int IDLE_CYCLES = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_sw_en,
    input  logic            i_auto_en,
    input  logic [N_CH-1:0] i_busy,
    input  logic            i_test_en,
    output logic [N_CH-1:0] o_clk,
    output logic [N_CH-1:0] o_clk_on
);

    localparam int               CNT_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  en_d;
    logic [N_CH-1:0]  lat_q;

    // Next-state and idle-counter logic for every channel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = '0;
        for (int k = 0; k < N_CH; k++) begin
            case (state_q[k])
                ST_OFF: begin
                    if (i_busy[k] || !i_auto_en) begin
                        state_d[k] = ST_ON;
                    end else begin
                        state_d[k] = ST_OFF;
                    end
                    cnt_d[k] = '0;
                end
                ST_ON: begin
                    if (i_auto_en && !i_busy[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        state_d[k] = ST_ON;
                        cnt_d[k]   = '0;
                    end
                end
                ST_IDLE: begin
                    if (i_busy[k] || !i_auto_en) begin
                        state_d[k] = ST_ON;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        state_d[k] = ST_OFF;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] < CNT_MAX) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = cnt_q[k] + CNT_ONE;
                    end else begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = cnt_q[k];
                    end
                end
                default: begin
                    state_d[k] = ST_OFF;
                    cnt_d[k]   = '0;
                end
            endcase
            // Software disable overrides busy, auto mode and the counter.
            if (!i_sw_en[k]) begin
                state_d[k] = ST_OFF;
                cnt_d[k]   = '0;
            end else begin
                state_d[k] = state_d[k];
            end
            en_d[k] = (state_d[k] != ST_OFF);
        end
    end

    // State, counter and gate-enable registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= ST_OFF;
                cnt_q[k]   <= '0;
            end
            en_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    // Enable latch, open only while the clock is low so a high phase is never cut.
    always_latch begin
        if (!i_rst_n) begin
            lat_q <= '0;
        end else if (!i_clk) begin
            lat_q <= en_q;
        end
    end

    assign o_clk    = i_test_en ? {N_CH{i_clk}} : ({N_CH{i_clk}} & lat_q);
    assign o_clk_on = en_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
`timescale 1ns/1ps
// Bench for clock_gate_ctrl: an on-time budget model checked every cycle,
// a pulse-width monitor, and directed scenarios with hand-computed counts.
module tb_clock_gate_ctrl;

    localparam int N_CH        = 4;
    localparam int IDLE_CYCLES = 8;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N_CH-1:0] sw_en   = '0;
    logic            auto_en = 1'b1;
    logic [N_CH-1:0] busy    = '0;
    logic            test_en = 1'b0;
    logic [N_CH-1:0] o_clk;
    logic [N_CH-1:0] o_clk_on;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .N_CH        (N_CH),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sw_en   (sw_en),
        .i_auto_en (auto_en),
        .i_busy    (busy),
        .i_test_en (test_en),
        .o_clk     (o_clk),
        .o_clk_on  (o_clk_on)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel stays enabled while sw_en is set and it is busy or
    // auto mode is off; afterwards it keeps IDLE_CYCLES more edges of on-time.
    logic [N_CH-1:0] m_en   = '0;
    logic [N_CH-1:0] m_prev = '0;
    int              m_left [N_CH];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_en <= '0;
            for (int k = 0; k < N_CH; k++) m_left[k] <= 0;
        end else begin
            m_prev <= m_en;
            for (int k = 0; k < N_CH; k++) begin
                if (!sw_en[k]) begin
                    m_en[k]   <= 1'b0;
                    m_left[k] <= 0;
                end else if (busy[k] || !auto_en) begin
                    m_en[k]   <= 1'b1;
                    m_left[k] <= IDLE_CYCLES;
                end else if (m_en[k] && m_left[k] > 0) begin
                    m_left[k] <= m_left[k] - 1;
                end else begin
                    m_en[k]   <= 1'b0;
                    m_left[k] <= 0;
                end
            end
            #2;
            check("model_clk_on", 32'(o_clk_on), 32'(m_en));
            check("model_clk", 32'(o_clk), test_en ? 32'(4'hF) : 32'(m_prev));
        end
    end

    // Pulse monitor: counts rising edges and checks each completed high pulse is 5 ns.
    logic [N_CH-1:0] mon_prev = '0;
    realtime         rise_t [N_CH];
    int              rise_cnt [N_CH];
    int              base [N_CH];

    always @(o_clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (o_clk[k] && !mon_prev[k]) begin
                rise_t[k]   = $realtime;
                rise_cnt[k] = rise_cnt[k] + 1;
            end else if (!o_clk[k] && mon_prev[k] && rst_n) begin
                check("pulse_width_ps", 32'(int'(($realtime - rise_t[k]) * 1000.0)), 32'd5000);
            end
        end
        mon_prev = o_clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int k = 0; k < N_CH; k++) base[k] = rise_cnt[k];
    endtask

    function automatic int pulses(input int k);
        return rise_cnt[k] - base[k];
    endfunction

    task automatic apply(input logic [3:0] s, input logic a, input logic [3:0] b,
                         input logic t, input int n);
        sw_en   = s;
        auto_en = a;
        busy    = b;
        test_en = t;
        cyc(n);
    endtask

    int drops = 0;

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            rise_cnt[k] = 0;
            base[k]     = 0;
            m_left[k]   = 0;
        end
        cyc(2);
        check("rst_clk_on", 32'(o_clk_on), 32'h0);
        @(posedge clk); #1;
        check("rst_clk_high", 32'(o_clk), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single busy pulse on channel 0 in auto mode.
        apply(4'hF, 1'b1, 4'h0, 1'b0, 2);
        busy = 4'b0001;
        snap();
        cyc(1);
        busy = 4'h0;
        cyc(8);
        check("s1_on_last_idle", 32'(o_clk_on[0]), 32'h1);
        cyc(1);
        check("s1_off", 32'(o_clk_on[0]), 32'h0);
        cyc(4);
        check("s1_pulses_ch0", 32'(pulses(0)), 32'(IDLE_CYCLES + 1));
        check("s1_pulses_ch3_1", 32'(pulses(1) + pulses(2) + pulses(3)), 32'h0);

        // Periodic busy on channel 1 keeps it running.
        snap();
        for (int i = 0; i < 40; i++) begin
            busy = (i % 5 == 0) ? 4'b0010 : 4'b0000;
            cyc(1);
            if (i > 0 && !o_clk_on[1]) drops++;
        end
        busy = 4'h0;
        check("s2_drops", 32'(drops), 32'h0);
        check("s2_pulses_ch1", 32'(pulses(1)), 32'd39);
        check("s2_pulses_ch0", 32'(pulses(0)), 32'h0);
        cyc(12);

        // Channel 2 disabled while idling at count 4.
        busy = 4'b0100;
        cyc(1);
        busy = 4'h0;
        snap();
        cyc(4);
        sw_en = 4'b1011;
        cyc(1);
        check("s3_off", 32'(o_clk_on[2]), 32'h0);
        cyc(5);
        check("s3_pulses_ch2", 32'(pulses(2)), 32'd5);
        sw_en = 4'hF;

        // Auto mode off: enabled channels free-run.
        apply(4'b0101, 1'b0, 4'h0, 1'b0, 0);
        snap();
        cyc(10);
        check("s4_pulses_ch0", 32'(pulses(0)), 32'd9);
        check("s4_pulses_ch1", 32'(pulses(1)), 32'h0);
        check("s4_pulses_ch2", 32'(pulses(2)), 32'd9);
        check("s4_pulses_ch3", 32'(pulses(3)), 32'h0);

        // Reset mid-pulse, then test bypass while reset is held.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #0.1;
        check("s5_clk0_drop", 32'(o_clk[0]), 32'h0);
        check("s5_clk_on", 32'(o_clk_on), 32'h0);
        @(negedge clk);
        test_en = 1'b1;
        @(posedge clk); #1;
        check("s5_test_high", 32'(o_clk), 32'hF);
        @(negedge clk); #1;
        check("s5_test_low", 32'(o_clk), 32'h0);
        test_en = 1'b0;
        @(posedge clk); #1;
        check("s5_hold_low", 32'(o_clk), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("s5_first_edge", 32'(o_clk_on), 32'h5);

        // Mixed vectors checked by the model every cycle.
        apply(4'hF,    1'b1, 4'hF,    1'b0, 1);
        apply(4'hF,    1'b1, 4'h0,    1'b0, 3);
        apply(4'hF,    1'b0, 4'h0,    1'b0, 1);
        apply(4'hF,    1'b1, 4'b0101, 1'b0, 2);
        apply(4'hF,    1'b1, 4'h0,    1'b0, 4);
        apply(4'b1100, 1'b1, 4'b0011, 1'b0, 2);
        apply(4'hF,    1'b1, 4'b1000, 1'b1, 3);
        apply(4'hF,    1'b1, 4'h0,    1'b0, 12);
        check("s6_all_off", 32'(o_clk_on), 32'h0);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
